// File: rtl/ldpc_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_pkg
// Constants and types shared by the LDPC decoder blocks.
//   - Default code geometry (check-node degree, LLR magnitude width)
//   - One-hot state encoding of the min-sum check-node processing unit
// ---------------------------------------------------------------------------
package ldpc_pkg;

    // Default check-node degree and LLR magnitude width of the decoder.
    localparam int LDPC_MAX_COLS  = 8;
    localparam int LDPC_WIDTH_LLR = 6;

    // Check-node processing unit states, one-hot.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_SCAN   = 4'b0010,
        ST_CALC   = 4'b0100,
        ST_RETURN = 4'b1000
    } pcu_state_t;

endpackage

// File: rtl/min2_tracker.sv
// ---------------------------------------------------------------------------
// min2_tracker
// Combinational next-state of the two-smallest-magnitudes tracker used by the
// min-sum check node. Feeding one column per call, it keeps the smallest
// magnitude (min1), its column index (idx) and the second smallest (min2).
// Strict less-than: the first occurrence of a minimum keeps idx, a later
// equal value becomes min2.
//
// Ports:
//   active    in   column takes part in the update (else state passes through)
//   mag       in   column magnitude
//   col       in   column index of mag
//   min1      in   current smallest magnitude
//   min2      in   current second smallest magnitude
//   idx       in   current column index of min1
//   min1_nxt  out  updated smallest magnitude
//   min2_nxt  out  updated second smallest magnitude
//   idx_nxt   out  updated column index of min1
// ---------------------------------------------------------------------------
module min2_tracker
    import ldpc_pkg::*;
#(
    parameter int WIDTH_LLR = LDPC_WIDTH_LLR,
    parameter int IDX_W     = 3
) (
    input  logic                 active,
    input  logic [WIDTH_LLR-1:0] mag,
    input  logic [IDX_W-1:0]     col,
    input  logic [WIDTH_LLR-1:0] min1,
    input  logic [WIDTH_LLR-1:0] min2,
    input  logic [IDX_W-1:0]     idx,
    output logic [WIDTH_LLR-1:0] min1_nxt,
    output logic [WIDTH_LLR-1:0] min2_nxt,
    output logic [IDX_W-1:0]     idx_nxt
);

    always_comb begin
        min1_nxt = min1;
        min2_nxt = min2;
        idx_nxt  = idx;
        if (active) begin
            if (mag < min1) begin
                min2_nxt = min1;
                min1_nxt = mag;
                idx_nxt  = col;
            end else if (mag < min2) begin
                min2_nxt = mag;
            end
        end
    end

endmodule

// File: rtl/pcu_minsum.sv
// ---------------------------------------------------------------------------
// pcu_minsum
// Min-sum check-node processing unit. On start, the column LLRs are captured,
// scanned one column per cycle to find min1/min2/idx and the sign parity,
// then the extrinsic magnitude/sign of every active column is computed in one
// cycle and held on the registered outputs until the next operation.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   operation request, accepted only when idle
//   llr_in    in   column magnitudes, column j at [j*WIDTH_LLR +: WIDTH_LLR]
//   sign_in   in   column signs (1 = negative)
//   col_mask  in   1 = column active
//   mode      in   0 = plain min-sum, 1 = offset min-sum
//   offset    in   offset subtracted from the magnitudes in mode 1
//   llr_out   out  extrinsic magnitudes (registered)
//   sign_out  out  extrinsic signs (registered)
//   busy      out  operation in progress
//   done      out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module pcu_minsum
    import ldpc_pkg::*;
#(
    parameter int MAX_COLS  = LDPC_MAX_COLS,
    parameter int WIDTH_LLR = LDPC_WIDTH_LLR
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [MAX_COLS*WIDTH_LLR-1:0] llr_in,
    input  logic [MAX_COLS-1:0]           sign_in,
    input  logic [MAX_COLS-1:0]           col_mask,
    input  logic                          mode,
    input  logic [WIDTH_LLR-1:0]          offset,
    output logic [MAX_COLS*WIDTH_LLR-1:0] llr_out,
    output logic [MAX_COLS-1:0]           sign_out,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(MAX_COLS - 1);

    // Subtraction clamped at zero so a large offset never wraps.
    function automatic logic [WIDTH_LLR-1:0] sat_sub(
        input logic [WIDTH_LLR-1:0] a,
        input logic [WIDTH_LLR-1:0] b
    );
        return (a > b) ? (a - b) : '0;
    endfunction

    pcu_state_t state, state_nxt;

    // Operands captured at start; held for the whole operation.
    logic [MAX_COLS*WIDTH_LLR-1:0] cap_llr;
    logic [MAX_COLS-1:0]           cap_sign;
    logic [MAX_COLS-1:0]           cap_mask;
    logic                          cap_mode;
    logic [WIDTH_LLR-1:0]          cap_offset;

    logic [IDX_W-1:0]     counter;
    logic [WIDTH_LLR-1:0] min1, min2;
    logic [IDX_W-1:0]     idx;
    logic                 parity;

    logic [WIDTH_LLR-1:0] mag_arr [MAX_COLS];
    logic [WIDTH_LLR-1:0] min1_nxt, min2_nxt;
    logic [IDX_W-1:0]     idx_nxt;

    logic [MAX_COLS*WIDTH_LLR-1:0] calc_llr;
    logic [MAX_COLS-1:0]           calc_sign;

    for (genvar g = 0; g < MAX_COLS; g++) begin : g_unpack
        assign mag_arr[g] = cap_llr[g*WIDTH_LLR +: WIDTH_LLR];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_SCAN;
            ST_SCAN:   if (counter == LAST_COL) state_nxt = ST_CALC;
            ST_CALC:   state_nxt = ST_RETURN;
            ST_RETURN: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_RETURN);

    // Operand capture (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start && !rst) begin
            cap_llr    <= llr_in;
            cap_sign   <= sign_in;
            cap_mask   <= col_mask;
            cap_mode   <= mode;
            cap_offset <= offset;
        end
    end

    min2_tracker #(
        .WIDTH_LLR (WIDTH_LLR),
        .IDX_W     (IDX_W)
    ) u_min2_tracker (
        .active   (cap_mask[counter]),
        .mag      (mag_arr[counter]),
        .col      (counter),
        .min1     (min1),
        .min2     (min2),
        .idx      (idx),
        .min1_nxt (min1_nxt),
        .min2_nxt (min2_nxt),
        .idx_nxt  (idx_nxt)
    );

    // Extrinsic values: each column sees the minimum of all the others,
    // which is min2 for the column that holds min1 and min1 for the rest.
    always_comb begin
        calc_llr  = '0;
        calc_sign = '0;
        for (int j = 0; j < MAX_COLS; j++) begin
            if (cap_mask[j]) begin
                if (IDX_W'(j) == idx) begin
                    calc_llr[j*WIDTH_LLR +: WIDTH_LLR] =
                        cap_mode ? sat_sub(min2, cap_offset) : min2;
                end else begin
                    calc_llr[j*WIDTH_LLR +: WIDTH_LLR] =
                        cap_mode ? sat_sub(min1, cap_offset) : min1;
                end
                calc_sign[j] = cap_sign[j] ^ parity;
            end
        end
    end

    // Scan / calc datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            counter  <= '0;
            min1     <= '1;
            min2     <= '1;
            idx      <= '0;
            parity   <= 1'b0;
            llr_out  <= '0;
            sign_out <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        counter <= '0;
                        min1    <= '1;
                        min2    <= '1;
                        idx     <= '0;
                        parity  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    min1   <= min1_nxt;
                    min2   <= min2_nxt;
                    idx    <= idx_nxt;
                    parity <= parity ^ (cap_mask[counter] & cap_sign[counter]);
                    if (counter != LAST_COL) begin
                        counter <= counter + 1'b1;
                    end
                end
                ST_CALC: begin
                    llr_out  <= calc_llr;
                    sign_out <= calc_sign;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcu_minsum.sv
// ---------------------------------------------------------------------------
// tb_pcu_minsum
// Self-checking bench for pcu_minsum (MAX_COLS=8, WIDTH_LLR=6): directed
// cases plus randomized operations compared with a reference model.
// ---------------------------------------------------------------------------
module tb_pcu_minsum;

    localparam int NC = 8;
    localparam int W  = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NC*W-1:0] llr_in;
    logic [NC-1:0]   sign_in;
    logic [NC-1:0]   col_mask;
    logic            mode;
    logic [W-1:0]    offset;
    logic [NC*W-1:0] llr_out;
    logic [NC-1:0]   sign_out;
    logic            busy;
    logic            done;

    int n_vec = 0;
    int n_mis = 0;

    pcu_minsum #(.MAX_COLS(NC), .WIDTH_LLR(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .llr_in   (llr_in),
        .sign_in  (sign_in),
        .col_mask (col_mask),
        .mode     (mode),
        .offset   (offset),
        .llr_out  (llr_out),
        .sign_out (sign_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: each active column gets the smallest magnitude among the
    // OTHER active columns (all-ones if none), minus offset clamped at 0 in
    // mode 1; sign is the XOR of the other active columns' signs.
    function automatic void model(input logic [NC*W-1:0] l, input logic [NC-1:0] s,
                                  input logic [NC-1:0] m, input logic md,
                                  input logic [W-1:0] off,
                                  output logic [NC*W-1:0] eo, output logic [NC-1:0] so);
        int others_min;
        int v;
        int par;
        eo = '0;
        so = '0;
        for (int j = 0; j < NC; j++) begin
            if (m[j]) begin
                others_min = 63;
                par = 0;
                for (int k = 0; k < NC; k++) begin
                    if (m[k] && k != j) begin
                        v = int'(l[k*W +: W]);
                        if (v < others_min) others_min = v;
                        par = par ^ int'(s[k]);
                    end
                end
                if (md) others_min = (others_min > int'(off)) ? others_min - int'(off) : 0;
                eo[j*W +: W] = W'(others_min);
                so[j] = par[0];
            end
        end
    endfunction

    function automatic logic [NC*W-1:0] pack(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [NC*W-1:0] r;
        r = {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
        return r;
    endfunction

    // Runs one operation; while busy the inputs are scrambled and a stray
    // start pulse is driven, none of which may affect the result.
    task automatic do_op(input string tag, input logic [NC*W-1:0] l, input logic [NC-1:0] s,
                         input logic [NC-1:0] m, input logic md, input logic [W-1:0] off);
        logic [NC*W-1:0] eo;
        logic [NC-1:0]   so;
        int n;
        logic busy_ok;
        model(l, s, m, md, off, eo, so);
        llr_in = l; sign_in = s; col_mask = m; mode = md; offset = off;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!done && n < 30) begin
            if (!busy) busy_ok = 1'b0;
            llr_in = {$urandom, $urandom};
            sign_in = NC'($urandom); col_mask = NC'($urandom);
            mode = 1'($urandom); offset = W'($urandom);
            start = (n == 3);
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({tag, "_done_cycle"}, 64'(n), 64'(NC + 2));
        check({tag, "_busy"}, {63'd0, busy_ok & busy}, 64'd1);
        check({tag, "_llr"}, 64'(llr_out), 64'(eo));
        check({tag, "_sign"}, 64'(sign_out), 64'(so));
        @(posedge clk); #1;
        check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold"}, {8'd0, llr_out, sign_out}, {8'd0, eo, so});
    endtask

    initial begin
        logic [NC*W-1:0] mags, ties;
        int n;
        int seen_done;
        rst = 1'b1; start = 1'b0; llr_in = '0; sign_in = '0; col_mask = '0;
        mode = 1'b0; offset = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {8'd0, llr_out, sign_out, busy, done}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        mags = pack(10, 4, 9, 6, 12, 7, 20, 8);
        do_op("plain", mags, 8'b0000_0101, 8'hFF, 1'b0, 6'd0);
        check("plain_vals", 64'(llr_out), 64'(pack(4, 6, 4, 4, 4, 4, 4, 4)));
        check("plain_sgn", 64'(sign_out), 64'h05);
        do_op("offset", mags, 8'b0000_0101, 8'hFF, 1'b1, 6'd5);
        check("offset_vals", 64'(llr_out), 64'(pack(0, 1, 0, 0, 0, 0, 0, 0)));
        do_op("mask0f", mags, 8'b0000_0111, 8'h0F, 1'b0, 6'd0);
        check("mask0f_vals", 64'(llr_out), 64'(pack(4, 6, 4, 4, 0, 0, 0, 0)));
        check("mask0f_sgn", 64'(sign_out), 64'h08);
        ties = pack(3, 3, 9, 9, 9, 9, 9, 9);
        do_op("tie", ties, 8'h00, 8'hFF, 1'b0, 6'd0);
        check("tie_vals", 64'(llr_out), 64'(pack(3, 3, 3, 3, 3, 3, 3, 3)));
        do_op("single", ties, 8'h01, 8'h01, 1'b0, 6'd0);
        check("single_vals", 64'(llr_out), 64'(pack(63, 0, 0, 0, 0, 0, 0, 0)));
        do_op("single_off", mags, 8'h10, 8'h10, 1'b1, 6'd7);
        do_op("none", mags, 8'hFF, 8'h00, 1'b1, 6'd1);

        // Reset in the middle of an operation.
        llr_in = mags; sign_in = 8'h05; col_mask = 8'hFF; mode = 1'b0; offset = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", {8'd0, llr_out, sign_out, busy, done}, 64'd0);
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        do_op("after_abort", mags, 8'b0000_0101, 8'hFF, 1'b0, 6'd0);

        for (int t = 0; t < 40; t++) begin
            logic [NC*W-1:0] rl;
            for (int j = 0; j < NC; j++)
                rl[j*W +: W] = (t % 4 == 0) ? W'($urandom_range(0, 4)) : W'($urandom);
            do_op($sformatf("rnd%0d", t), rl, NC'($urandom),
                  (t % 7 == 0) ? NC'(8'h01 << (t % 8)) : NC'($urandom),
                  1'($urandom), W'($urandom_range(0, 40)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
